// File: rtl/wallace_mul16_seq_if.sv
// Operand/result handshake bundle for the sequential 16x16 multiplier.
// The master side produces operands and consumes products; the slave side is the multiplier.
interface wallace_mul16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  modport master (
    output in_valid, a, b, abort, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, abort, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/wallace_mul16_seq.sv
// Multi-cycle 16x16 unsigned multiplier: one shared 8x8 Wallace-tree multiplier is stepped
// through the byte partial products, which are accumulated into a 32-bit product.

// 8x8 unsigned multiplier: eight partial-product rows reduced by 3:2 carry-save layers.
module wallace (
  input  logic [7:0]  a_0,
  input  logic [7:0]  b_0,
  output logic [15:0] result
);
  logic [15:0] pp_s [8];
  logic [31:0] l1a_s, l1b_s, l2a_s, l2b_s, l3_s, l4_s;

  // Returns {carry, sum}; the carry row is already shifted into its weight.
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 4'd1;
    return {c, s};
  endfunction

  // Partial-product row generation
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp_s[i] = ({8'd0, a_0} & {16{b_0[i]}}) << i;
    end
  end

  assign l1a_s  = csa(pp_s[0], pp_s[1], pp_s[2]);
  assign l1b_s  = csa(pp_s[3], pp_s[4], pp_s[5]);
  assign l2a_s  = csa(l1a_s[15:0], l1a_s[31:16], l1b_s[15:0]);
  assign l2b_s  = csa(l1b_s[31:16], pp_s[6], pp_s[7]);
  assign l3_s   = csa(l2a_s[15:0], l2a_s[31:16], l2b_s[15:0]);
  assign l4_s   = csa(l3_s[15:0], l3_s[31:16], l2b_s[31:16]);
  assign result = l4_s[15:0] + l4_s[31:16];
endmodule

module wallace_mul16_seq #(
  parameter bit EARLY_DONE = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  wallace_mul16_seq_if.slave bus_if
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  step_q, step_d;
  logic [31:0] product_q, product_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  logic [7:0]  mul_a_s, mul_b_s;
  logic [15:0] mul_res_s;
  logic [31:0] partial_s;
  logic        run1_s, run2_s, run3_s;
  logic        last_s;
  logic [1:0]  next_step_s;

  wallace u_wallace (
    .a_0    (mul_a_s),
    .b_0    (mul_b_s),
    .result (mul_res_s)
  );

  // A step can only be skipped when the byte it multiplies by is zero.
  assign run1_s = (EARLY_DONE == 1'b0) || (b_q[15:8] != 8'd0);
  assign run2_s = (EARLY_DONE == 1'b0) || (a_q[15:8] != 8'd0);
  assign run3_s = run1_s && run2_s;

  // Operand byte select and shift of the partial product for the current step
  always_comb begin
    mul_a_s   = a_q[7:0];
    mul_b_s   = b_q[7:0];
    partial_s = {16'd0, mul_res_s};
    case (step_q)
      2'd0: begin
        mul_a_s   = a_q[7:0];
        mul_b_s   = b_q[7:0];
        partial_s = {16'd0, mul_res_s};
      end
      2'd1: begin
        mul_a_s   = a_q[7:0];
        mul_b_s   = b_q[15:8];
        partial_s = {8'd0, mul_res_s, 8'd0};
      end
      2'd2: begin
        mul_a_s   = a_q[15:8];
        mul_b_s   = b_q[7:0];
        partial_s = {8'd0, mul_res_s, 8'd0};
      end
      2'd3: begin
        mul_a_s   = a_q[15:8];
        mul_b_s   = b_q[15:8];
        partial_s = {mul_res_s, 16'd0};
      end
      default: begin
        mul_a_s   = a_q[7:0];
        mul_b_s   = b_q[7:0];
        partial_s = {16'd0, mul_res_s};
      end
    endcase
  end

  // Next enabled step after the current one; last_s when none remains
  always_comb begin
    next_step_s = 2'd0;
    last_s      = 1'b1;
    case (step_q)
      2'd0: begin
        if (run1_s) begin
          next_step_s = 2'd1;
          last_s      = 1'b0;
        end else if (run2_s) begin
          next_step_s = 2'd2;
          last_s      = 1'b0;
        end else if (run3_s) begin
          next_step_s = 2'd3;
          last_s      = 1'b0;
        end else begin
          last_s      = 1'b1;
        end
      end
      2'd1: begin
        if (run2_s) begin
          next_step_s = 2'd2;
          last_s      = 1'b0;
        end else if (run3_s) begin
          next_step_s = 2'd3;
          last_s      = 1'b0;
        end else begin
          last_s      = 1'b1;
        end
      end
      2'd2: begin
        if (run3_s) begin
          next_step_s = 2'd3;
          last_s      = 1'b0;
        end else begin
          last_s      = 1'b1;
        end
      end
      2'd3:    last_s = 1'b1;
      default: last_s = 1'b1;
    endcase
  end

  // Job sequencing; abort overrides every other request on the same edge
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    step_d    = step_q;
    product_d = product_q;
    if (bus_if.abort) begin
      state_d = ST_IDLE;
      acc_d   = 32'd0;
      step_d  = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.in_valid) begin
            a_d     = bus_if.a;
            b_d     = bus_if.b;
            acc_d   = 32'd0;
            step_d  = 2'd0;
            state_d = ST_MUL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          acc_d = acc_q + partial_s;
          if (last_s) begin
            product_d = acc_q + partial_s;
            step_d    = 2'd0;
            state_d   = ST_DONE;
          end else begin
            step_d    = next_step_s;
          end
        end
        ST_DONE: begin
          if (bus_if.out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      acc_q       <= 32'd0;
      step_q      <= 2'd0;
      product_q   <= 32'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus_if.in_ready  = in_ready_q;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.product   = product_q;
  assign bus_if.busy      = busy_q;
endmodule
